// File: rtl/fpga_conf_spi_if.sv
// SPI pins plus configuration outputs of the FPGA configuration receiver.
// The ARM side drives through master; the receiver uses slave.
interface fpga_conf_spi_if #(
  parameter int ADDR_W   = 2,
  parameter int WORD_W   = 8,
  parameter int NUM_REGS = 4
);
  logic                       spck;
  logic                       mosi;
  logic                       ncs;
  logic                       miso;
  logic [NUM_REGS*WORD_W-1:0] conf_flat;
  logic [2:0]                 major_mode;
  logic                       conf_wr_stb;
  logic [ADDR_W-1:0]          conf_wr_addr;
  logic                       frame_err;

  modport master (output spck, mosi, ncs,
                  input  miso, conf_flat, major_mode, conf_wr_stb, conf_wr_addr, frame_err);
  modport slave  (input  spck, mosi, ncs,
                  output miso, conf_flat, major_mode, conf_wr_stb, conf_wr_addr, frame_err);
endinterface

// File: rtl/fpga_conf_spi.sv
// Oversampled SPI configuration receiver: address+data frames commit into a
// register bank on ncs rise, with readback of the addressed register on miso.
module fpga_conf_spi #(
  parameter int                ADDR_W     = 2,
  parameter int                WORD_W     = 8,
  parameter int                NUM_REGS   = 4,
  parameter logic [WORD_W-1:0] REG0_RESET = 8'hE0
) (
  input  logic            ck_1356meg,
  input  logic            nreset,
  fpga_conf_spi_if.slave  bus
);
  localparam int FRM_W = ADDR_W + WORD_W;
  localparam int CNT_W = $clog2(FRM_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRM_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRM_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [ADDR_W:0]   NREG_L   = (ADDR_W+1)'(NUM_REGS);

  logic [1:0]                         r_spck_s, r_mosi_s, r_ncs_s;
  logic                               r_spck_d, r_ncs_d;
  logic [FRM_W-1:0]                   r_sh;
  logic [CNT_W-1:0]                   r_cnt;
  logic                               r_ld;
  logic [WORD_W-1:0]                  r_rd;
  logic [NUM_REGS-1:0][WORD_W-1:0]    r_regs;
  logic [2:0]                         r_mode;
  logic                               r_stb, r_err;
  logic [ADDR_W-1:0]                  r_wr_addr;

  logic                w_ncs_rise, w_ncs_fall, w_shift, w_fall, w_wr_ok;
  logic [ADDR_W-1:0]   w_frm_addr, w_rd_addr;
  logic [WORD_W-1:0]   w_frm_data, w_rd_val;

  // Unused modes 101/110 collapse to "everything off".
  function automatic logic [2:0] f_mode(input logic [2:0] f);
    return (f == 3'b101 || f == 3'b110) ? 3'b111 : f;
  endfunction

  assign w_ncs_rise = r_ncs_s[1] & ~r_ncs_d;
  assign w_ncs_fall = ~r_ncs_s[1] & r_ncs_d;
  // Both edges qualify on sync'd ncs low, so an ncs rise always wins.
  assign w_shift    = r_spck_s[1] & ~r_spck_d & ~r_ncs_s[1];
  assign w_fall     = ~r_spck_s[1] & r_spck_d & ~r_ncs_s[1];
  assign w_frm_addr = r_sh[FRM_W-1 -: ADDR_W];
  assign w_frm_data = r_sh[WORD_W-1:0];
  assign w_rd_addr  = r_sh[ADDR_W-1:0];
  assign w_wr_ok    = (r_cnt == CNT_FULL) && ({1'b0, w_frm_addr} < NREG_L);

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_rd_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      r_spck_s  <= '0;
      r_mosi_s  <= '0;
      r_ncs_s   <= 2'b11;
      r_spck_d  <= 1'b0;
      r_ncs_d   <= 1'b1;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_ld      <= 1'b0;
      r_rd      <= '0;
      r_regs    <= '0;
      r_regs[0] <= REG0_RESET;
      r_mode    <= 3'b111;
      r_stb     <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_spck_s <= {r_spck_s[0], bus.spck};
      r_mosi_s <= {r_mosi_s[0], bus.mosi};
      r_ncs_s  <= {r_ncs_s[0],  bus.ncs};
      r_spck_d <= r_spck_s[1];
      r_ncs_d  <= r_ncs_s[1];
      r_stb    <= 1'b0;
      r_ld     <= 1'b0;
      if (w_ncs_rise) begin
        r_rd <= '0;
        if (r_cnt != '0) begin
          if (w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (w_frm_addr == ADDR_W'(i)) r_regs[i] <= w_frm_data;
            if (w_frm_addr == '0) r_mode <= f_mode(w_frm_data[WORD_W-1 -: 3]);
            r_stb     <= 1'b1;
            r_wr_addr <= w_frm_addr;
            r_err     <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (w_ncs_fall) begin
        r_cnt <= '0;
        r_sh  <= '0;
        r_rd  <= '0;
      end else begin
        if (w_shift) begin
          r_sh <= {r_sh[FRM_W-2:0], r_mosi_s[1]};
          if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
          r_ld <= (r_cnt == CNT_LAST_ADDR);
        end
        // Load happens after the last address bit; a phase is >= 3 cycles so no fall collides.
        if (r_ld)        r_rd <= w_rd_val;
        else if (w_fall) r_rd <= {r_rd[WORD_W-2:0], 1'b0};
      end
    end
  end

  assign bus.miso         = r_rd[WORD_W-1];
  assign bus.conf_flat    = r_regs;
  assign bus.major_mode   = r_mode;
  assign bus.conf_wr_stb  = r_stb;
  assign bus.conf_wr_addr = r_wr_addr;
  assign bus.frame_err    = r_err;
endmodule

// File: tb/tb_fpga_conf_spi.sv
// Directed bench for fpga_conf_spi: a 4-register and a 3-register instance
// share the SPI pins; committed writes are scoreboarded against queues.
module tb_fpga_conf_spi;
  localparam int HALF = 8;

  typedef struct packed { logic [1:0] addr; logic [7:0] data; } wr_t;

  logic clk = 1'b0, rst_n = 1'b0, spck = 1'b0, mosi = 1'b0, ncs = 1'b1;
  int   checks = 0, failures = 0;
  wr_t  q4[$], q3[$];
  logic [7:0] mdl4 [4];
  logic [7:0] mdl3 [3];

  always #5 clk = ~clk;

  fpga_conf_spi_if #(.ADDR_W(2), .WORD_W(8), .NUM_REGS(4)) b4();
  fpga_conf_spi_if #(.ADDR_W(2), .WORD_W(8), .NUM_REGS(3)) b3();
  assign b4.spck = spck;  assign b4.mosi = mosi;  assign b4.ncs = ncs;
  assign b3.spck = spck;  assign b3.mosi = mosi;  assign b3.ncs = ncs;

  fpga_conf_spi #(.ADDR_W(2), .WORD_W(8), .NUM_REGS(4), .REG0_RESET(8'hE0))
    dut  (.ck_1356meg(clk), .nreset(rst_n), .bus(b4));
  fpga_conf_spi #(.ADDR_W(2), .WORD_W(8), .NUM_REGS(3), .REG0_RESET(8'hE0))
    dut3 (.ck_1356meg(clk), .nreset(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flat4();
    return {mdl4[3], mdl4[2], mdl4[1], mdl4[0]};
  endfunction
  function automatic logic [31:0] flat3();
    return {8'h00, mdl3[2], mdl3[1], mdl3[0]};
  endfunction

  task automatic model_reset();
    mdl4 = '{8'hE0, 8'h00, 8'h00, 8'h00};
    mdl3 = '{8'hE0, 8'h00, 8'h00};
    q4.delete(); q3.delete();
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [7:0] d);
    q4.push_back('{addr: a, data: d});
    mdl4[a] = d;
    if (a < 2'd3) begin
      q3.push_back('{addr: a, data: d});
      mdl3[a] = d;
    end
  endtask

  // Strobe monitors: every pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    if (b4.conf_wr_stb === 1'b1) begin
      chk("stb4_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("stb4_addr", 32'(b4.conf_wr_addr), 32'(e.addr));
        chk("stb4_data", 32'(b4.conf_flat[e.addr*8 +: 8]), 32'(e.data));
      end
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (b3.conf_wr_stb === 1'b1) begin
      chk("stb3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("stb3_addr", 32'(b3.conf_wr_addr), 32'(e.addr));
        chk("stb3_data", 32'(b3.conf_flat[e.addr*8 +: 8]), 32'(e.data));
      end
    end
  end

  // Shift n bits MSB first; miso is sampled just before each falling spck edge.
  task automatic clk_bits(input int n, input logic [15:0] bits, input bit ck,
                          input logic [7:0] rd4, input logic [7:0] rd3, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      int   idx;
      logic e4, e3;
      idx  = n - 1 - i;
      mosi = bits[i];
      repeat (HALF) @(negedge clk);
      spck = 1'b1;
      repeat (HALF) @(negedge clk);
      if (ck) begin
        e4 = (idx >= 1 && idx <= 8) ? rd4[8 - idx] : 1'b0;
        e3 = (idx >= 1 && idx <= 8) ? rd3[8 - idx] : 1'b0;
        chk({tag, "_miso4"}, 32'(b4.miso), 32'(e4));
        chk({tag, "_miso3"}, 32'(b3.miso), 32'(e3));
      end
      spck = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [15:0] bits, input bit ck,
                       input logic [7:0] rd4, input logic [7:0] rd3, input string tag);
    @(negedge clk); ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    clk_bits(n, bits, ck, rd4, rd3, tag);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (HALF + 4) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [2:0] mode, input logic err4, input logic err3);
    chk({tag, "_flat4"}, b4.conf_flat, flat4());
    chk({tag, "_flat3"}, 32'(b3.conf_flat), flat3());
    chk({tag, "_mode4"}, 32'(b4.major_mode), 32'(mode));
    chk({tag, "_mode3"}, 32'(b3.major_mode), 32'(mode));
    chk({tag, "_err4"}, 32'(b4.frame_err), 32'(err4));
    chk({tag, "_err3"}, 32'(b3.frame_err), 32'(err3));
    chk({tag, "_q4_drained"}, 32'(q4.size()), 32'd0);
    chk({tag, "_q3_drained"}, 32'(q3.size()), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1 reset state
    check_state("T1", 3'b111, 1'b0, 1'b0);
    chk("T1_miso", 32'(b4.miso), 32'd0);
    chk("T1_stb", 32'(b4.conf_wr_stb), 32'd0);
    chk("T1_wr_addr", 32'(b4.conf_wr_addr), 32'd0);

    // T2 write reg1; readback shows the pre-write value
    expect_wr(2'd1, 8'h5A);
    frame(10, {6'd0, 2'd1, 8'h5A}, 1'b1, 8'h00, 8'h00, "T2");
    check_state("T2", 3'b111, 1'b0, 1'b0);
    chk("T2_wr_addr", 32'(b4.conf_wr_addr), 32'd1);
    chk("T2_miso_idle", 32'(b4.miso), 32'd0);

    // T3 mode 011, then readback of reg0 while writing mode 001
    expect_wr(2'd0, 8'h60);
    frame(10, {6'd0, 2'd0, 8'h60}, 1'b1, 8'hE0, 8'hE0, "T3a");
    check_state("T3a", 3'b011, 1'b0, 1'b0);
    expect_wr(2'd0, 8'h21);
    frame(10, {6'd0, 2'd0, 8'h21}, 1'b1, 8'h60, 8'h60, "T3b");
    check_state("T3b", 3'b001, 1'b0, 1'b0);
    chk("T3_wr_addr", 32'(b4.conf_wr_addr), 32'd0);

    // T4 bad lengths set the error; good frames clear it; empty frames leave it
    frame(7, 16'h0055, 1'b0, 8'h00, 8'h00, "T4a");
    check_state("T4a", 3'b001, 1'b1, 1'b1);
    expect_wr(2'd2, 8'hC3);
    frame(10, {6'd0, 2'd2, 8'hC3}, 1'b1, 8'h00, 8'h00, "T4b");
    check_state("T4b", 3'b001, 1'b0, 1'b0);
    frame(0, 16'h0000, 1'b0, 8'h00, 8'h00, "T4c");
    check_state("T4c", 3'b001, 1'b0, 1'b0);
    frame(11, 16'h05A5, 1'b0, 8'h00, 8'h00, "T4d");
    check_state("T4d", 3'b001, 1'b1, 1'b1);
    frame(0, 16'h0000, 1'b0, 8'h00, 8'h00, "T4e");
    check_state("T4e", 3'b001, 1'b1, 1'b1);
    expect_wr(2'd1, 8'h0F);
    frame(10, {6'd0, 2'd1, 8'h0F}, 1'b1, 8'h5A, 8'h5A, "T4f");
    check_state("T4f", 3'b001, 1'b0, 1'b0);

    // T5 unused mode is stored but reported as off; addr 3 only exists on the 4-reg instance
    expect_wr(2'd0, 8'hA0);
    frame(10, {6'd0, 2'd0, 8'hA0}, 1'b1, 8'h21, 8'h21, "T5a");
    check_state("T5a", 3'b111, 1'b0, 1'b0);
    expect_wr(2'd3, 8'h77);
    frame(10, {6'd0, 2'd3, 8'h77}, 1'b1, 8'h00, 8'h00, "T5b");
    check_state("T5b", 3'b111, 1'b0, 1'b1);
    chk("T5b_wr_addr4", 32'(b4.conf_wr_addr), 32'd3);
    chk("T5b_wr_addr3", 32'(b3.conf_wr_addr), 32'd0);

    // T6 reset after 5 bits abandons the frame
    @(negedge clk); ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    clk_bits(5, 16'h0017, 1'b0, 8'h00, 8'h00, "T6");
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    chk("T6_stb_in_reset", 32'(b4.conf_wr_stb), 32'd0);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    check_state("T6a", 3'b111, 1'b0, 1'b0);
    chk("T6_wr_addr", 32'(b4.conf_wr_addr), 32'd0);
    expect_wr(2'd2, 8'h3C);
    frame(10, {6'd0, 2'd2, 8'h3C}, 1'b1, 8'h00, 8'h00, "T6b");
    check_state("T6b", 3'b111, 1'b0, 1'b0);
    chk("T6b_wr_addr", 32'(b4.conf_wr_addr), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
